// File: rtl/cpu_instrmem_gen2.sv
// Instruction memory with a loader write port, a 1-cycle-latency read port and
// a hardware zero-fill engine.
//
// The byte-addressed store is held as an array of words because every access
// that reaches the array is aligned. Misaligned reads return zero with
// rd_fault set. Misaligned writes are dropped and pulse wr_fault.
// While the zero-fill runs (busy=1) reads are ignored and writes are not
// accepted (wr_ready=0).
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset, highest priority
//   rd_req     read request, accepted only when idle
//   rd_addr    read byte address
//   rd_data    read word, little-endian; holds value between reads
//   rd_valid   1-cycle pulse, one cycle after an accepted read
//   rd_fault   misaligned read, qualified by rd_valid
//   wr_valid   loader write request
//   wr_ready   write port accepts (idle)
//   wr_addr    write byte address
//   wr_data    write word, little-endian
//   wr_fault   1-cycle pulse, misaligned write dropped
//   clear_req  request zero-fill of the whole memory (ignored while busy)
//   busy       zero-fill in progress
module cpu_instrmem_gen2 #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned WORD_BYTES     = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    rd_fault,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    wr_fault,
    input  logic                    clear_req,
    output logic                    busy
);

    localparam int unsigned DATA_W    = 8 * WORD_BYTES;
    localparam int unsigned OFFS_W    = $clog2(WORD_BYTES);
    localparam int unsigned NUM_WORDS = (2 ** ADDR_W) / WORD_BYTES;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // Low address bits that must be zero for an aligned access.
    localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   mem_q [NUM_WORDS];

    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                rd_fault_q;
    logic                wr_fault_q;

    logic                rd_mis;
    logic                wr_mis;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                rd_acc;
    logic                wr_acc;

    logic                mem_we;
    logic [IDX_W-1:0]    mem_widx;
    logic [DATA_W-1:0]   mem_wdata;

    // Address decode and handshake
    always_comb begin
        rd_mis   = (rd_addr & OFFS_MASK) != '0;
        wr_mis   = (wr_addr & OFFS_MASK) != '0;
        rd_idx   = IDX_W'(rd_addr >> OFFS_W);
        wr_idx   = IDX_W'(wr_addr >> OFFS_W);
        busy     = (state_q == StClear);
        wr_ready = (state_q == StIdle);
        rd_acc   = rd_req && (state_q == StIdle);
        wr_acc   = wr_valid && wr_ready;
    end

    // Single array write port shared by the clear engine and the loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = wr_idx;
        mem_wdata = wr_data;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_widx  = cnt_q;
            mem_wdata = '0;
        end else if (wr_acc && !wr_mis) begin
            mem_we = 1'b1;
        end
    end

    // Array has no reset of its own; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // Control FSM with registered read/fault outputs. The read samples the
    // array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StIdle;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_fault_q <= 1'b0;
            wr_fault_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            rd_fault_q <= rd_acc && rd_mis;
            wr_fault_q <= wr_acc && wr_mis;
            if (rd_acc) begin
                rd_data_q <= rd_mis ? '0 : mem_q[rd_idx];
            end
            unique case (state_q)
                StClear: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= StIdle;
                    end
                    cnt_q <= cnt_q + IDX_W'(1);
                end
                StIdle: begin
                    if (clear_req) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_fault = rd_fault_q;
    assign wr_fault = wr_fault_q;

endmodule

// File: tb/tb_cpu_instrmem_gen2.sv
// Scoreboard bench for cpu_instrmem_gen2 (ADDR_W=6, WORD_BYTES=4).
// The stimulus process updates a byte-level memory model at each clock edge
// and queues expected read responses; a negedge monitor pops and compares.
// A second instance with CLEAR_ON_RESET=0 runs alongside.
module tb_cpu_instrmem_gen2;

    localparam int unsigned AW = 6;
    localparam int unsigned WB = 4;
    localparam int unsigned NW = 16;
    localparam int unsigned NB = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CLEAR_ON_RESET=1)
    logic          rst, rd_req, wr_valid, clear_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   wr_data, rd_data;
    logic          rd_valid, rd_fault, wr_ready, wr_fault, busy;

    // Secondary instance (CLEAR_ON_RESET=0)
    logic          rst0, rd_req0, wr_valid0, clear_req0;
    logic [AW-1:0] rd_addr0, wr_addr0;
    logic [31:0]   wr_data0, rd_data0;
    logic          rd_valid0, rd_fault0, wr_ready0, wr_fault0, busy0;

    cpu_instrmem_gen2 #(
        .ADDR_W        (AW),
        .WORD_BYTES    (WB),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_fault (rd_fault),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_fault (wr_fault),
        .clear_req(clear_req),
        .busy     (busy)
    );

    cpu_instrmem_gen2 #(
        .ADDR_W        (AW),
        .WORD_BYTES    (WB),
        .CLEAR_ON_RESET(1'b0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst0),
        .rd_req   (rd_req0),
        .rd_addr  (rd_addr0),
        .rd_data  (rd_data0),
        .rd_valid (rd_valid0),
        .rd_fault (rd_fault0),
        .wr_valid (wr_valid0),
        .wr_ready (wr_ready0),
        .wr_addr  (wr_addr0),
        .wr_data  (wr_data0),
        .wr_fault (wr_fault0),
        .clear_req(clear_req0),
        .busy     (busy0)
    );

    // Reference model state
    logic [7:0]  mem_m  [NB];
    logic [7:0]  mem0_m [NB];
    int          clear_left   = 0;
    bit          exp_rd_valid = 1'b0;
    bit          exp_wr_fault = 1'b0;
    logic [31:0] exp_hold     = '0;
    logic [31:0] exp0_hold    = '0;
    bit          exp0_rd_valid = 1'b0;
    logic [32:0] rd_q  [$];
    logic [31:0] rd0_q [$];

    bit checking   = 1'b0;
    bit finish_req = 1'b0;
    bit fin_done   = 1'b0;
    int n_checks   = 0;
    int n_fail     = 0;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_m[int'(a) + k];
        return w;
    endfunction

    function automatic logic [31:0] word0_of(input logic [AW-1:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem0_m[int'(a) + k];
        return w;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 99) < 85) a = AW'($urandom_range(0, NW - 1) * WB);
        else a = AW'($urandom_range(0, NB - 1));
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: inputs are stable here, so the model applies the same
    // rules the memory should: reset, clear window, read-then-write, clear.
    task automatic cycle();
        logic [31:0] w;
        bit          mis;
        @(posedge clk);
        exp_rd_valid = 1'b0;
        exp_wr_fault = 1'b0;
        if (rst) begin
            clear_left = NW;
            exp_hold   = '0;
            for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (rd_req) begin
                mis = (rd_addr % WB) != 0;
                w   = mis ? 32'h0 : word_of(rd_addr);
                rd_q.push_back({mis, w});
                exp_rd_valid = 1'b1;
                exp_hold     = w;
            end
            if (wr_valid) begin
                if ((wr_addr % WB) != 0) exp_wr_fault = 1'b1;
                else for (int k = 0; k < 4; k++) mem_m[int'(wr_addr) + k] = wr_data[8*k +: 8];
            end
            if (clear_req) begin
                clear_left = NW;
                for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
            end
        end
        exp0_rd_valid = 1'b0;
        if (rst0) begin
            exp0_hold = '0;
        end else begin
            if (rd_req0) begin
                w = word0_of(rd_addr0);
                rd0_q.push_back(w);
                exp0_rd_valid = 1'b1;
                exp0_hold     = w;
            end
            if (wr_valid0) begin
                for (int k = 0; k < 4; k++) mem0_m[int'(wr_addr0) + k] = wr_data0[8*k +: 8];
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && clear_left > 0; i++) cycle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_req = 1'b1; rd_addr = a;
        cycle();
        rd_req = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        logic [32:0] e;
        logic [31:0] e0;
        if (checking) begin
            check("busy", busy, clear_left > 0);
            check("wr_ready", wr_ready, clear_left == 0);
            check("wr_fault", wr_fault, exp_wr_fault);
            check("rd_valid", rd_valid, exp_rd_valid);
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("rd_valid_unexpected", rd_valid, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_data", rd_data, e[31:0]);
                    check("rd_fault", rd_fault, e[32]);
                end
            end else begin
                check("rd_fault_idle", rd_fault, 0);
                check("rd_data_hold", rd_data, exp_hold);
            end
            check("busy0", busy0, 0);
            check("wr_ready0", wr_ready0, 1);
            check("wr_fault0", wr_fault0, 0);
            check("rd_valid0", rd_valid0, exp0_rd_valid);
            if (rd_valid0) begin
                if (rd0_q.size() == 0) begin
                    check("rd_valid0_unexpected", rd_valid0, 0);
                end else begin
                    e0 = rd0_q.pop_front();
                    check("rd_data0", rd_data0, e0);
                    check("rd_fault0", rd_fault0, 0);
                end
            end else begin
                check("rd_data0_hold", rd_data0, exp0_hold);
            end
            if (finish_req && !fin_done) begin
                check("rd_queue_drained", rd_q.size(), 0);
                check("rd0_queue_drained", rd0_q.size(), 0);
                fin_done = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; clear_req = 1'b0;
        rst0 = 1'b1; rd_req0 = 1'b0; rd_addr0 = '0; wr_valid0 = 1'b0; wr_addr0 = '0;
        wr_data0 = '0; clear_req0 = 1'b0;
        cycle();
        rst = 1'b0; rst0 = 1'b0; checking = 1'b1;

        // Secondary instance accepts a write right after reset.
        wr_valid0 = 1'b1; wr_addr0 = 6'h04; wr_data0 = 32'hCAFE_F00D;
        cycle();
        wr_valid0 = 1'b0; rd_req0 = 1'b1; rd_addr0 = 6'h04;
        cycle();
        rd_req0 = 1'b0;

        // Reset clear runs to completion, then the whole memory reads zero.
        wait_idle();
        for (int i = 0; i < NW; i++) begin
            rd_req = 1'b1; rd_addr = AW'(i * WB);
            cycle();
        end
        rd_req = 1'b0;

        // Basic write/read and misaligned accesses.
        do_write(6'h08, 32'hDEAD_BEEF);
        do_read(6'h08);
        do_read(6'h09);
        do_write(6'h0A, 32'h1234_5678);
        do_read(6'h08);

        // Same-cycle read/write collision returns old data.
        do_write(6'h10, 32'h1111_1111);
        rd_req = 1'b1; rd_addr = 6'h10;
        wr_valid = 1'b1; wr_addr = 6'h10; wr_data = 32'h2222_2222;
        cycle();
        rd_req = 1'b0; wr_valid = 1'b0;
        do_read(6'h10);

        // Clear requested together with a write: the write lands, then is zeroed.
        wr_valid = 1'b1; wr_addr = 6'h20; wr_data = 32'hA5A5_A5A5; clear_req = 1'b1;
        cycle();
        wr_valid = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        // Re-request and read during CLEAR: both ignored.
        clear_req = 1'b1; rd_req = 1'b1; rd_addr = 6'h00;
        cycle();
        clear_req = 1'b0; rd_req = 1'b0;
        wait_idle();
        do_read(6'h20);
        do_read(6'h08);

        // Reset in the middle of a clear restarts it.
        do_write(6'h3C, 32'h0BAD_CAFE);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_idle();
        do_read(6'h3C);

        // Secondary instance reset mid-run: still ready the next cycle.
        rst0 = 1'b1;
        cycle();
        rst0 = 1'b0;
        rd_req0 = 1'b1; rd_addr0 = 6'h04;
        cycle();
        rd_req0 = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            rd_req    = $urandom_range(0, 1) == 1;
            rd_addr   = rand_addr();
            wr_valid  = $urandom_range(0, 1) == 1;
            wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr : rand_addr();
            wr_data   = $urandom();
            clear_req = $urandom_range(0, 59) == 0;
            rst       = $urandom_range(0, 199) == 0;
            cycle();
        end
        rd_req = 1'b0; wr_valid = 1'b0; clear_req = 1'b0; rst = 1'b0;
        wait_idle();
        for (int i = 0; i < NW; i++) begin
            rd_req = 1'b1; rd_addr = AW'(i * WB);
            cycle();
        end
        rd_req = 1'b0;

        cycle();
        finish_req = 1'b1;
        cycle();
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_instrmem_gen2.md
CPU_INSTRMEM_GEN2 -- requirements
Module: cpu_instrmem_gen2

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, 16, byte-address width; memory holds 2^ADDR_W bytes.
- WORD_BYTES, 4, bytes per access; power of two, 1..2^ADDR_W.
- CLEAR_ON_RESET, 1, 1 = zero-fill memory after reset; 0 = contents undefined after reset.

REQ-002 SHALL have ports, one per line; clock is clk; reset is rst, synchronous, active-high:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  read byte address
- rd_data  out  8*WORD_BYTES  read word, little-endian
- rd_valid  out  1  read result valid, 1-cycle pulse
- rd_fault  out  1  read address misaligned, qualified by rd_valid
- wr_valid  in  1  loader write request
- wr_ready  out  1  write port accepts
- wr_addr  in  ADDR_W  write byte address
- wr_data  in  8*WORD_BYTES  write word, little-endian
- wr_fault  out  1  1-cycle pulse, misaligned write dropped
- clear_req  in  1  request zero-fill of whole memory
- busy  out  1  zero-fill in progress

Function
REQ-003 SHALL store 2^ADDR_W bytes. Word at aligned address A: byte A at bits [7:0], byte A+k at bits [8k+7:8k].
REQ-004 SHALL define aligned as addr mod WORD_BYTES == 0. Aligned words never cross the top of memory; no wrap-around path exists.
REQ-005 SHALL implement FSM states CLEAR and IDLE.
REQ-006 CLEAR transitions:
- In CLEAR, zero one aligned word per cycle at counter*WORD_BYTES.
- Counter runs 0 .. 2^ADDR_W/WORD_BYTES-1.
- Go to IDLE the cycle after the last word is written.
REQ-007 busy SHALL be 1 exactly while state==CLEAR; wr_ready SHALL be 1 exactly while state==IDLE.
REQ-008 clear_req in IDLE SHALL enter CLEAR next cycle with counter=0; clear_req in CLEAR SHALL be ignored (no restart).
REQ-009 Read in IDLE, 1-cycle latency:
- rd_req with aligned rd_addr: next cycle rd_valid=1, rd_fault=0, rd_data=word.
- rd_req with misaligned rd_addr: next cycle rd_valid=1, rd_fault=1, rd_data=0.
REQ-010 rd_req in CLEAR SHALL be ignored: rd_valid=0 next cycle.
REQ-011 Without an accepted rd_req, rd_valid and rd_fault SHALL be 0; rd_data SHALL hold its last value.
REQ-012 Write accepted when wr_valid&&wr_ready:
- Aligned: all WORD_BYTES bytes written at the clock edge.
- Misaligned: memory unchanged; wr_fault=1 next cycle.
REQ-013 Read and write in the same cycle at the same address SHALL return the old data (read-before-write).
REQ-014 clear_req and an accepted write in the same IDLE cycle: the write completes, then CLEAR starts and later zeroes it.
REQ-015 Throughput SHALL be one read and one write per cycle in IDLE, with no bubbles.

Reset
REQ-016 rst SHALL take priority over all inputs.
REQ-017 Output values at the clock edge where rst=1:
- rd_data=0, rd_valid=0, rd_fault=0, wr_fault=0.
- If CLEAR_ON_RESET=1: state=CLEAR, counter=0, busy=1, wr_ready=0.
- If CLEAR_ON_RESET=0: state=IDLE, busy=0, wr_ready=1.
REQ-018 rst asserted mid-CLEAR SHALL restart the clear at counter=0.
REQ-019 Memory array SHALL NOT be reset directly; it is only cleared by the CLEAR state.

Verification (ADDR_W=6, WORD_BYTES=4 unless stated)
REQ-020 Reset clear:
- Stimulus: rst 1 cycle, then idle.
- Response: busy=1 for exactly 16 cycles, then wr_ready=1; reads at 0x00..0x3C return 0.
REQ-021 Write/read:
- Stimulus: write 0xDEADBEEF @0x08, then rd_req @0x08.
- Response: rd_valid=1 one cycle later, rd_data=0xDEADBEEF; read @0x09 -> rd_valid=1, rd_fault=1, rd_data=0.
REQ-022 Misaligned write:
- Stimulus: wr_valid @0x0A, data 0x12345678.
- Response: wr_fault pulse; read @0x08 unchanged.
REQ-023 Same-cycle collision:
- Stimulus: 0x11111111 @0x10; then read+write 0x22222222 @0x10 in one cycle.
- Response: that read returns 0x11111111; next read returns 0x22222222.
REQ-024 Clear:
- Stimulus: clear_req in IDLE, clear_req re-asserted at cycle 5 of CLEAR.
- Response: busy for 16 cycles total, no restart; rd_req during busy gives no rd_valid.
REQ-025 Reset mid-clear:
- Stimulus: rst at cycle 7 of CLEAR.
- Response: busy stays 1 for 16 further cycles.
- Also run CLEAR_ON_RESET=0: wr_ready=1 the cycle after reset.
